serial_add_sched: RTL and testbench

Bit-serial adder scheduler that shares one pair of half-adder cells between two requesters. It arbitrates round-robin and latches the winner's WIDTH-bit operands. It then sequences the half-adder pair LSB-first, one bit per clock, with a registered carry, and returns a registered WIDTH-bit sum plus carry-out with a done pulse. It sits between the requesting blocks and the `sum_pre`/`carry_pre` half-adder primitives, trading latency for minimal adder area.

---
 rtl/serial_add_sched.sv | 150 +++++++++++++++
 tb/tb_serial_add_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sched.sv
// serial_add_sched
// Bit-serial adder scheduler: one pair of half-adder cells is shared between
// two requesters. A round-robin arbiter picks a requester, its operands are
// latched into shift registers, and the sum is built one bit per clock
// (LSB first) with a registered carry. The result is held until the next
// completion.

module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             req0_in,
    input  logic [WIDTH-1:0] a0_in,
    input  logic [WIDTH-1:0] b0_in,
    input  logic             req1_in,
    input  logic [WIDTH-1:0] a1_in,
    input  logic [WIDTH-1:0] b1_in,
    output logic [1:0]       gnt_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             owner_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             carry_reg;
    logic [CW-1:0]    cnt;
    logic             last_owner;
    logic             cur_owner;

    logic             grant0;
    logic             grant1;
    logic             any_req;
    logic             last_bit;

    logic             s1;
    logic             c1;
    logic             s;
    logic             c2;
    logic             carry_nxt;

    // Round-robin choice: a lone request wins outright; on a tie the
    // requester that was not served last time wins.
    always_comb begin
        grant0 = req0_in & (~req1_in | last_owner);
        grant1 = req1_in & ~grant0;
        any_req = req0_in | req1_in;
    end

    // The two shared half-adder cells, chained through the registered carry.
    // Operands sit LSB-first at position 0 of their shift registers.
    always_comb begin
        s1        = a_sr[0] ^ b_sr[0];
        c1        = a_sr[0] & b_sr[0];
        s         = s1 ^ carry_reg;
        c2        = s1 & carry_reg;
        carry_nxt = c1 | c2;
        res_nxt   = {s, res_sr[WIDTH-1:1]};
        last_bit  = (cnt == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave IDLE on any request, leave RUN after the last bit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = RUN;
            RUN:  if (last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs: grant/latch in IDLE, one bit per
    // clock in RUN, results published with a done pulse on the last bit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            carry_reg  <= 1'b0;
            cnt        <= '0;
            last_owner <= 1'b1;
            cur_owner  <= 1'b0;
            gnt_out    <= 2'b00;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            owner_out  <= 1'b0;
            sum_out    <= '0;
            carry_out  <= 1'b0;
        end else begin
            gnt_out  <= 2'b00;
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_out    <= {grant1, grant0};
                        busy_out   <= 1'b1;
                        a_sr       <= grant1 ? a1_in : a0_in;
                        b_sr       <= grant1 ? b1_in : b0_in;
                        res_sr     <= '0;
                        carry_reg  <= 1'b0;
                        cnt        <= '0;
                        cur_owner  <= grant1;
                        last_owner <= grant1;
                    end
                end
                RUN: begin
                    a_sr      <= a_sr >> 1;
                    b_sr      <= b_sr >> 1;
                    res_sr    <= res_nxt;
                    carry_reg <= carry_nxt;
                    cnt       <= cnt + CW'(1);
                    if (last_bit) begin
                        sum_out   <= res_nxt;
                        carry_out <= carry_nxt;
                        owner_out <= cur_owner;
                        done_out  <= 1'b1;
                        busy_out  <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Testbench for serial_add_sched: directed vectors on a WIDTH=8 instance,
// plus operand sweeps on WIDTH=4 and WIDTH=32 instances.

module tb_serial_add_sched;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;

    int checks = 0;
    int errors = 0;

    // WIDTH=8 instance signals
    logic       req0_8 = 0, req1_8 = 0;
    logic [7:0] a0_8 = 0, b0_8 = 0, a1_8 = 0, b1_8 = 0;
    logic [1:0] gnt_8;
    logic       busy_8, done_8, owner_8, carry_8;
    logic [7:0] sum_8;

    // WIDTH=4 instance signals
    logic       req0_4 = 0, req1_4 = 0;
    logic [3:0] a0_4 = 0, b0_4 = 0, a1_4 = 0, b1_4 = 0;
    logic [1:0] gnt_4;
    logic       busy_4, done_4, owner_4, carry_4;
    logic [3:0] sum_4;

    // WIDTH=32 instance signals
    logic        req0_32 = 0, req1_32 = 0;
    logic [31:0] a0_32 = 0, b0_32 = 0, a1_32 = 0, b1_32 = 0;
    logic [1:0]  gnt_32;
    logic        busy_32, done_32, owner_32, carry_32;
    logic [31:0] sum_32;

    serial_add_sched #(.WIDTH(8)) dut8 (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req0_in(req0_8), .a0_in(a0_8), .b0_in(b0_8),
        .req1_in(req1_8), .a1_in(a1_8), .b1_in(b1_8),
        .gnt_out(gnt_8), .busy_out(busy_8), .done_out(done_8),
        .owner_out(owner_8), .sum_out(sum_8), .carry_out(carry_8)
    );

    serial_add_sched #(.WIDTH(4)) dut4 (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req0_in(req0_4), .a0_in(a0_4), .b0_in(b0_4),
        .req1_in(req1_4), .a1_in(a1_4), .b1_in(b1_4),
        .gnt_out(gnt_4), .busy_out(busy_4), .done_out(done_4),
        .owner_out(owner_4), .sum_out(sum_4), .carry_out(carry_4)
    );

    serial_add_sched #(.WIDTH(32)) dut32 (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req0_in(req0_32), .a0_in(a0_32), .b0_in(b0_32),
        .req1_in(req1_32), .a1_in(a1_32), .b1_in(b1_32),
        .gnt_out(gnt_32), .busy_out(busy_32), .done_out(done_32),
        .owner_out(owner_32), .sum_out(sum_32), .carry_out(carry_32)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int sel, input logic r0, input logic r1);
        case (sel)
            8:  begin req0_8  = r0; req1_8  = r1; end
            4:  begin req0_4  = r0; req1_4  = r1; end
            32: begin req0_32 = r0; req1_32 = r1; end
            default: ;
        endcase
    endtask

    task automatic setOps(input int sel, input int who, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            8:  if (who == 0) begin a0_8 = a[7:0]; b0_8 = b[7:0]; end
                else begin a1_8 = a[7:0]; b1_8 = b[7:0]; end
            4:  if (who == 0) begin a0_4 = a[3:0]; b0_4 = b[3:0]; end
                else begin a1_4 = a[3:0]; b1_4 = b[3:0]; end
            32: if (who == 0) begin a0_32 = a; b0_32 = b; end
                else begin a1_32 = a; b1_32 = b; end
            default: ;
        endcase
    endtask

    task automatic sampleOut(input int sel, output logic [1:0] g, output logic d, output logic bz,
                             output logic ow, output logic cy, output logic [31:0] s);
        g = 2'b00; d = 0; bz = 0; ow = 0; cy = 0; s = 32'h0;
        case (sel)
            8:  begin g = gnt_8;  d = done_8;  bz = busy_8;  ow = owner_8;  cy = carry_8;  s = {24'h0, sum_8}; end
            4:  begin g = gnt_4;  d = done_4;  bz = busy_4;  ow = owner_4;  cy = carry_4;  s = {28'h0, sum_4}; end
            32: begin g = gnt_32; d = done_32; bz = busy_32; ow = owner_32; cy = carry_32; s = sum_32; end
            default: ;
        endcase
    endtask

    // Tick until done is seen; lat is the number of edges waited, -1 on timeout.
    task automatic waitDone(input int sel, output int lat);
        logic [1:0] g; logic d, bz, ow, cy; logic [31:0] s;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            sampleOut(sel, g, d, bz, ow, cy, s);
            if (g != 2'b00) begin
                checkOutput("gnt_during_run", {62'h0, g}, 64'h0);
            end
            if (d) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic checkResult(input string tag, input int sel, input int who,
                               input logic [31:0] exp_sum, input logic exp_carry);
        logic [1:0] g; logic d, bz, ow, cy; logic [31:0] s;
        sampleOut(sel, g, d, bz, ow, cy, s);
        checkOutput({tag, "_sum"},   {32'h0, s},  {32'h0, exp_sum});
        checkOutput({tag, "_carry"}, {63'h0, cy}, {63'h0, exp_carry});
        checkOutput({tag, "_owner"}, {63'h0, ow}, 64'(who));
        checkOutput({tag, "_busy"},  {63'h0, bz}, 64'h0);
    endtask

    // One complete transaction: request, check grant, scramble operands,
    // wait for done, check latency and result.
    task automatic applyStimulus(input string tag, input int sel, input int who,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_sum, input logic exp_carry);
        logic [1:0] g; logic d, bz, ow, cy; logic [31:0] s;
        int lat;
        setOps(sel, who, a, b);
        setReq(sel, who == 0, who == 1);
        tick();
        sampleOut(sel, g, d, bz, ow, cy, s);
        checkOutput({tag, "_gnt"},  {62'h0, g},  (who == 0) ? 64'h1 : 64'h2);
        checkOutput({tag, "_gbusy"}, {63'h0, bz}, 64'h1);
        setReq(sel, 1'b0, 1'b0);
        setOps(sel, who, ~a, ~b);
        waitDone(sel, lat);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(sel));
        checkResult(tag, sel, who, exp_sum, exp_carry);
    endtask

    task automatic sweepAdd(input string tag, input int sel, input int who,
                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        logic [63:0] mask;
        mask = (64'h1 << sel) - 64'h1;
        e = ({32'h0, a} & mask) + ({32'h0, b} & mask);
        applyStimulus(tag, sel, who, a, b, 32'(e & mask), e[sel]);
    endtask

    initial begin
        logic [1:0] g; logic d, bz, ow, cy; logic [31:0] s;
        int lat;
        int done_seen;

        // Reset state
        #1;
        sampleOut(8, g, d, bz, ow, cy, s);
        checkOutput("rst_gnt",   {62'h0, g},  64'h0);
        checkOutput("rst_busy",  {63'h0, bz}, 64'h0);
        checkOutput("rst_done",  {63'h0, d},  64'h0);
        checkOutput("rst_owner", {63'h0, ow}, 64'h0);
        checkOutput("rst_sum",   {32'h0, s},  64'h0);
        checkOutput("rst_carry", {63'h0, cy}, 64'h0);
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();

        // Simultaneous requests right after reset: requester 0 first
        setOps(8, 0, 32'h11, 32'h22);
        setOps(8, 1, 32'hF0, 32'h20);
        setReq(8, 1'b1, 1'b1);
        tick();
        sampleOut(8, g, d, bz, ow, cy, s);
        checkOutput("tie_gnt0", {62'h0, g}, 64'h1);
        setReq(8, 1'b0, 1'b1);
        setOps(8, 0, 32'hFF, 32'hFF);
        waitDone(8, lat);
        checkOutput("tie_lat0", 64'(lat), 64'd8);
        checkResult("tie_r0", 8, 0, 32'h33, 1'b0);
        tick();
        sampleOut(8, g, d, bz, ow, cy, s);
        checkOutput("tie_gnt1", {62'h0, g}, 64'h2);
        checkOutput("tie_done_low", {63'h0, d}, 64'h0);
        setReq(8, 1'b0, 1'b0);
        waitDone(8, lat);
        checkOutput("tie_lat1", 64'(lat), 64'd8);
        checkResult("tie_r1", 8, 1, 32'h10, 1'b1);

        // Fairness: both requests held for four transactions
        setOps(8, 0, 32'h12, 32'h34);
        setOps(8, 1, 32'h80, 32'h80);
        setReq(8, 1'b1, 1'b1);
        for (int t = 0; t < 4; t++) begin
            tick();
            sampleOut(8, g, d, bz, ow, cy, s);
            checkOutput("fair_gnt", {62'h0, g}, (t % 2 == 0) ? 64'h1 : 64'h2);
            for (int k = 0; k < 3; k++) tick();
            sampleOut(8, g, d, bz, ow, cy, s);
            checkOutput("fair_mid_gnt",  {62'h0, g},  64'h0);
            checkOutput("fair_mid_busy", {63'h0, bz}, 64'h1);
            waitDone(8, lat);
            checkOutput("fair_lat", 64'(lat), 64'd5);
            if (t % 2 == 0) checkResult("fair_r0", 8, 0, 32'h46, 1'b0);
            else            checkResult("fair_r1", 8, 1, 32'h00, 1'b1);
            if (t == 3) setReq(8, 1'b0, 1'b0);
        end

        // Directed single adds
        applyStimulus("ff_01", 8, 0, 32'hFF, 32'h01, 32'h00, 1'b1);
        applyStimulus("00_00", 8, 0, 32'h00, 32'h00, 32'h00, 1'b0);
        applyStimulus("a5_5a", 8, 1, 32'hA5, 32'h5A, 32'hFF, 1'b0);

        // Reset during bit 3 of an add
        setOps(8, 0, 32'h3C, 32'h0F);
        setReq(8, 1'b1, 1'b0);
        tick();
        setReq(8, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        #2;
        rst_n_in = 1'b0;
        #1;
        sampleOut(8, g, d, bz, ow, cy, s);
        checkOutput("mrst_gnt",   {62'h0, g},  64'h0);
        checkOutput("mrst_busy",  {63'h0, bz}, 64'h0);
        checkOutput("mrst_done",  {63'h0, d},  64'h0);
        checkOutput("mrst_owner", {63'h0, ow}, 64'h0);
        checkOutput("mrst_sum",   {32'h0, s},  64'h0);
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done_8) done_seen++;
        end
        rst_n_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done_8) done_seen++;
        end
        checkOutput("mrst_no_done", 64'(done_seen), 64'h0);
        applyStimulus("7f_01", 8, 0, 32'h7F, 32'h01, 32'h80, 1'b0);

        // Parameter sweep
        applyStimulus("w4_f_1", 4, 0, 32'hF, 32'h1, 32'h0, 1'b1);
        for (int t = 0; t < 6; t++) begin
            sweepAdd("w4_rand", 4, t % 2, $urandom_range(0, 15), $urandom_range(0, 15));
        end
        applyStimulus("w32_max", 32, 1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1);
        for (int t = 0; t < 4; t++) begin
            sweepAdd("w32_rand", 32, t % 2, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
